// File: rtl/frame_writer.sv
// Framebuffer writer: accepts a framed RGB pixel stream, tracks raster position and issues one
// 32-bit write per pixel. Optional double buffering is enabled with FRAME_WRITER_DOUBLE_BUFFER_EN.
module frame_writer #(
   parameter int unsigned Height      = 600,
   parameter int unsigned Width       = 800,
   parameter logic [31:0] BaseAddress = 32'h0000_0000
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        slave_valid_i,
   output logic        slave_ready_o,
   input  logic [7:0]  slave_red_i,
   input  logic [7:0]  slave_green_i,
   input  logic [7:0]  slave_blue_i,
   input  logic        slave_last_i,
   output logic        mem_valid_o,
   input  logic        mem_ready_i,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_data_o,
   output logic        frame_done_o,
   output logic [15:0] error_count_o,
   output logic        buffer_index_o
);

   localparam logic [31:0] FrameBytes = 32'(Height * Width * 4);
   localparam int unsigned RowW = (Height > 1) ? $clog2(Height) : 1;
   localparam int unsigned ColW = (Width > 1) ? $clog2(Width) : 1;
   localparam logic [RowW-1:0] LastRow = RowW'(Height - 1);
   localparam logic [ColW-1:0] LastCol = ColW'(Width - 1);

   typedef enum logic [0:0] {
      RUN,
      RESYNC
   } state_t;

   state_t            state_q, state_n;
   logic [RowW-1:0]   row_q, row_n;
   logic [ColW-1:0]   col_q, col_n;
   logic [31:0]       addr_q, addr_n;
   logic              buf_q, buf_n;
   logic [15:0]       err_q, err_n;
   logic              mv_q, mv_n;
   logic [31:0]       ma_q, ma_n;
   logic [31:0]       md_q, md_n;
   logic              tag_q, tag_n;
   logic              err_inc;
   logic              beat_accept;
   logic              write_accept;
   logic              at_final;
   logic              buf_flip;
   logic [31:0]       flip_base;

`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
   assign buf_flip = ~buf_q;
`else
   assign buf_flip = 1'b0;
`endif
   // Base of the frame that starts after the current boundary.
   assign flip_base = BaseAddress + (buf_flip ? FrameBytes : '0);

   assign slave_ready_o  = (state_q == RESYNC) || !mv_q || mem_ready_i;
   assign beat_accept    = slave_valid_i && slave_ready_o;
   assign write_accept   = mv_q && mem_ready_i;
   assign at_final       = (row_q == LastRow) && (col_q == LastCol);

   assign mem_valid_o    = mv_q;
   assign mem_address_o  = ma_q;
   assign mem_data_o     = md_q;
   assign frame_done_o   = write_accept && tag_q;
   assign error_count_o  = err_q;
   assign buffer_index_o = buf_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= RUN;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= BaseAddress;
         buf_q   <= 1'b0;
         err_q   <= '0;
         mv_q    <= 1'b0;
         ma_q    <= '0;
         md_q    <= '0;
         tag_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         row_q   <= row_n;
         col_q   <= col_n;
         addr_q  <= addr_n;
         buf_q   <= buf_n;
         err_q   <= err_n;
         mv_q    <= mv_n;
         ma_q    <= ma_n;
         md_q    <= md_n;
         tag_q   <= tag_n;
      end
   end

   always_comb begin
      state_n = state_q;
      row_n   = row_q;
      col_n   = col_q;
      addr_n  = addr_q;
      buf_n   = buf_q;
      err_n   = err_q;
      mv_n    = mv_q;
      ma_n    = ma_q;
      md_n    = md_q;
      tag_n   = tag_q;
      err_inc = 1'b0;

      // Drain first so a same-cycle reload below overrides it without loss or duplication.
      if (write_accept) begin
         mv_n  = 1'b0;
         tag_n = 1'b0;
      end

      if (beat_accept) begin
         if (state_q == RUN) begin
            mv_n  = 1'b1;
            ma_n  = addr_q;
            md_n  = {8'h00, slave_red_i, slave_green_i, slave_blue_i};
            tag_n = at_final && slave_last_i;
            if (slave_last_i) begin
               row_n   = '0;
               col_n   = '0;
               addr_n  = flip_base;
               buf_n   = buf_flip;
               err_inc = !at_final;
            end else if (at_final) begin
               err_inc = 1'b1;
               state_n = RESYNC;
            end else begin
               addr_n = addr_q + 32'd4;
               if (col_q == LastCol) begin
                  col_n = '0;
                  row_n = row_q + 1'b1;
               end else begin
                  col_n = col_q + 1'b1;
               end
            end
         end else if (slave_last_i) begin
            state_n = RUN;
            row_n   = '0;
            col_n   = '0;
            addr_n  = flip_base;
            buf_n   = buf_flip;
         end
      end

      if (err_inc && (err_q != 16'hFFFF)) begin
         err_n = err_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer (Height=2, Width=3, BaseAddress=32'h1000).
module tb_frame_writer;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        slave_valid_i = 1'b0;
   logic        slave_ready_o;
   logic [7:0]  slave_red_i = '0;
   logic [7:0]  slave_green_i = '0;
   logic [7:0]  slave_blue_i = '0;
   logic        slave_last_i = 1'b0;
   logic        mem_valid_o;
   logic        mem_ready_i = 1'b1;
   logic [31:0] mem_address_o;
   logic [31:0] mem_data_o;
   logic        frame_done_o;
   logic [15:0] error_count_o;
   logic        buffer_index_o;

   int checks = 0;
   int errors = 0;
   int done_pulses = 0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic        wdone_q[$];

`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
   localparam bit DoubleBuf = 1'b1;
`else
   localparam bit DoubleBuf = 1'b0;
`endif

   frame_writer #(
      .Height      (2),
      .Width       (3),
      .BaseAddress (32'h1000)
   ) dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .slave_valid_i  (slave_valid_i),
      .slave_ready_o  (slave_ready_o),
      .slave_red_i    (slave_red_i),
      .slave_green_i  (slave_green_i),
      .slave_blue_i   (slave_blue_i),
      .slave_last_i   (slave_last_i),
      .mem_valid_o    (mem_valid_o),
      .mem_ready_i    (mem_ready_i),
      .mem_address_o  (mem_address_o),
      .mem_data_o     (mem_data_o),
      .frame_done_o   (frame_done_o),
      .error_count_o  (error_count_o),
      .buffer_index_o (buffer_index_o)
   );

   always #5 clock_i = ~clock_i;

   // Inputs change just after posedge, so the falling edge sees settled handshakes.
   always @(negedge clock_i) begin
      if (reset_i) begin
         if (mem_valid_o && mem_ready_i) begin
            wa_q.push_back(mem_address_o);
            wd_q.push_back(mem_data_o);
            wdone_q.push_back(frame_done_o);
         end
         if (frame_done_o) done_pulses++;
      end
   end

   function automatic logic [31:0] pix(input int k);
      return {8'h00, 8'(k), 8'(k + 32), 8'(k + 64)};
   endfunction

   task automatic apply_reset;
      reset_i = 1'b0;
      slave_valid_i = 1'b0;
      slave_last_i = 1'b0;
      mem_ready_i = 1'b1;
      repeat (2) @(posedge clock_i);
      #1 reset_i = 1'b1;
      wa_q.delete();
      wd_q.delete();
      wdone_q.delete();
      done_pulses = 0;
   endtask

   task automatic send_beat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic last);
      bit ok = 1'b0;
      slave_valid_i = 1'b1;
      slave_red_i = r;
      slave_green_i = g;
      slave_blue_i = b;
      slave_last_i = last;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock_i);
         if (slave_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_beat_timeout: slave_ready_o stayed 0, required 1 within 50 cycles");
      end
      @(posedge clock_i);
      #1;
      slave_valid_i = 1'b0;
      slave_last_i = 1'b0;
   endtask

   task automatic send_pix(input int k, input logic last);
      send_beat(8'(k), 8'(k + 32), 8'(k + 64), last);
   endtask

   task automatic drain;
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock_i);
         if (!mem_valid_o) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL drain_timeout: mem_valid_o stayed 1, required 0 within 50 cycles");
      end
      @(posedge clock_i);
      #1;
   endtask

   task automatic test_reset;
      reset_i = 1'b0;
      mem_ready_i = 1'b1;
      repeat (2) @(posedge clock_i);
      #1;
      checks += 7;
      if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid_o); end
      if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done_o); end
      if (error_count_o !== 16'h0) begin errors++; $display("FAIL reset_err: got %h want 0", error_count_o); end
      if (buffer_index_o !== 1'b0) begin errors++; $display("FAIL reset_buf: got %b want 0", buffer_index_o); end
      if (mem_address_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_address_o); end
      if (mem_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mem_data_o); end
      if (slave_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", slave_ready_o); end
   endtask

   task automatic test_good_frame;
      logic [31:0] exp_d;
      apply_reset();
      send_beat(8'd10, 8'd20, 8'd30, 1'b0);
      for (int k = 2; k <= 6; k++) send_pix(k, k == 6);
      drain();
      checks++;
      if (wa_q.size() !== 6) begin errors++; $display("FAIL good_count: got %0d want 6", wa_q.size()); end
      for (int k = 0; k < 6 && k < wa_q.size(); k++) begin
         exp_d = (k == 0) ? 32'h000A141E : pix(k + 1);
         checks += 3;
         if (wa_q[k] !== 32'(32'h1000 + 4 * k)) begin errors++; $display("FAIL good_addr[%0d]: got %h want %h", k, wa_q[k], 32'(32'h1000 + 4 * k)); end
         if (wd_q[k] !== exp_d) begin errors++; $display("FAIL good_data[%0d]: got %h want %h", k, wd_q[k], exp_d); end
         if (wdone_q[k] !== (k == 5)) begin errors++; $display("FAIL good_done[%0d]: got %b want %b", k, wdone_q[k], k == 5); end
      end
      checks += 2;
      if (done_pulses !== 1) begin errors++; $display("FAIL good_done_pulses: got %0d want 1", done_pulses); end
      if (error_count_o !== 16'd0) begin errors++; $display("FAIL good_err: got %0d want 0", error_count_o); end
   endtask

   task automatic test_stall;
      apply_reset();
      send_pix(1, 1'b0);
      send_pix(2, 1'b0);
      mem_ready_i = 1'b0;
      repeat (5) begin
         @(negedge clock_i);
         checks += 4;
         if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", mem_valid_o); end
         if (mem_address_o !== 32'h1004) begin errors++; $display("FAIL stall_addr: got %h want 00001004", mem_address_o); end
         if (mem_data_o !== pix(2)) begin errors++; $display("FAIL stall_data: got %h want %h", mem_data_o, pix(2)); end
         if (slave_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", slave_ready_o); end
      end
      @(posedge clock_i);
      #1 mem_ready_i = 1'b1;
      for (int k = 3; k <= 6; k++) send_pix(k, k == 6);
      drain();
      checks++;
      if (wa_q.size() !== 6) begin errors++; $display("FAIL stall_count: got %0d want 6", wa_q.size()); end
      for (int k = 0; k < 6 && k < wa_q.size(); k++) begin
         checks += 2;
         if (wa_q[k] !== 32'(32'h1000 + 4 * k)) begin errors++; $display("FAIL stall_addr[%0d]: got %h want %h", k, wa_q[k], 32'(32'h1000 + 4 * k)); end
         if (wd_q[k] !== pix(k + 1)) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", k, wd_q[k], pix(k + 1)); end
      end
      checks++;
      if (done_pulses !== 1) begin errors++; $display("FAIL stall_done_pulses: got %0d want 1", done_pulses); end
   endtask

   task automatic test_early_last;
      logic [31:0] exp_a;
      apply_reset();
      for (int k = 1; k <= 4; k++) send_pix(k, k == 4);
      send_pix(5, 1'b0);
      drain();
      checks++;
      if (wa_q.size() !== 5) begin errors++; $display("FAIL early_count: got %0d want 5", wa_q.size()); end
      for (int k = 0; k < 5 && k < wa_q.size(); k++) begin
         exp_a = (k < 4) ? 32'(32'h1000 + 4 * k) : 32'h1000;
         checks += 2;
         if (wa_q[k] !== exp_a) begin errors++; $display("FAIL early_addr[%0d]: got %h want %h", k, wa_q[k], exp_a); end
         if (wd_q[k] !== pix(k + 1)) begin errors++; $display("FAIL early_data[%0d]: got %h want %h", k, wd_q[k], pix(k + 1)); end
      end
      checks += 2;
      if (done_pulses !== 0) begin errors++; $display("FAIL early_done_pulses: got %0d want 0", done_pulses); end
      if (error_count_o !== 16'd1) begin errors++; $display("FAIL early_err: got %0d want 1", error_count_o); end
   endtask

   task automatic test_missing_last;
      logic [31:0] exp_a, exp_d;
      apply_reset();
      for (int k = 1; k <= 6; k++) send_pix(k, 1'b0);
      for (int k = 7; k <= 9; k++) send_pix(k, k == 9);
      send_pix(10, 1'b0);
      drain();
      checks++;
      if (wa_q.size() !== 7) begin errors++; $display("FAIL missing_count: got %0d want 7", wa_q.size()); end
      for (int k = 0; k < 7 && k < wa_q.size(); k++) begin
         exp_a = (k < 6) ? 32'(32'h1000 + 4 * k) : 32'h1000;
         exp_d = (k < 6) ? pix(k + 1) : pix(10);
         checks += 2;
         if (wa_q[k] !== exp_a) begin errors++; $display("FAIL missing_addr[%0d]: got %h want %h", k, wa_q[k], exp_a); end
         if (wd_q[k] !== exp_d) begin errors++; $display("FAIL missing_data[%0d]: got %h want %h", k, wd_q[k], exp_d); end
      end
      checks += 2;
      if (done_pulses !== 0) begin errors++; $display("FAIL missing_done_pulses: got %0d want 0", done_pulses); end
      if (error_count_o !== 16'd1) begin errors++; $display("FAIL missing_err: got %0d want 1", error_count_o); end
   endtask

   task automatic test_reset_mid_frame;
      apply_reset();
      mem_ready_i = 1'b0;
      send_pix(1, 1'b0);
      checks++;
      if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", mem_valid_o); end
      #1 reset_i = 1'b0;
      #1;
      checks++;
      if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b want 0", mem_valid_o); end
      repeat (2) @(posedge clock_i);
      #1 reset_i = 1'b1;
      mem_ready_i = 1'b1;
      wa_q.delete();
      wd_q.delete();
      wdone_q.delete();
      send_pix(3, 1'b0);
      drain();
      checks++;
      if (wa_q.size() !== 1) begin errors++; $display("FAIL midrst_count: got %0d want 1", wa_q.size()); end
      if (wa_q.size() > 0) begin
         checks += 2;
         if (wa_q[0] !== 32'h1000) begin errors++; $display("FAIL midrst_addr: got %h want 00001000", wa_q[0]); end
         if (wd_q[0] !== pix(3)) begin errors++; $display("FAIL midrst_data: got %h want %h", wd_q[0], pix(3)); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_a;
      apply_reset();
      checks++;
      if (buffer_index_o !== 1'b0) begin errors++; $display("FAIL b2b_buf0: got %b want 0", buffer_index_o); end
      for (int k = 1; k <= 6; k++) send_pix(k, k == 6);
      checks++;
      if (buffer_index_o !== DoubleBuf) begin errors++; $display("FAIL b2b_buf1: got %b want %b", buffer_index_o, DoubleBuf); end
      for (int k = 7; k <= 12; k++) send_pix(k, k == 12);
      drain();
      checks += 2;
      if (buffer_index_o !== 1'b0) begin errors++; $display("FAIL b2b_buf2: got %b want 0", buffer_index_o); end
      if (wa_q.size() !== 12) begin errors++; $display("FAIL b2b_count: got %0d want 12", wa_q.size()); end
      for (int k = 0; k < 12 && k < wa_q.size(); k++) begin
         exp_a = (k < 6) ? 32'(32'h1000 + 4 * k)
                         : 32'((DoubleBuf ? 32'h1018 : 32'h1000) + 4 * (k - 6));
         checks += 2;
         if (wa_q[k] !== exp_a) begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, wa_q[k], exp_a); end
         if (wd_q[k] !== pix(k + 1)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, wd_q[k], pix(k + 1)); end
      end
      checks += 2;
      if (done_pulses !== 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 2", done_pulses); end
      if (error_count_o !== 16'd0) begin errors++; $display("FAIL b2b_err: got %0d want 0", error_count_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_good_frame();
      test_stall();
      test_early_last();
      test_missing_last();
      test_reset_mid_frame();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
